// File: rtl/serial_feed_arbiter.sv
// Round-robin feeder that serialises one granted word MSB-first into a shared
// sequence detector and counts the detector hits that belong to that word.
module serial_feed_arbiter #(
  parameter int WIDTH   = 8,
  parameter int CNTW    = 4,
  parameter int DET_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ser_out,
  input  logic             det_in,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CNTW-1:0]  hit_cnt
);

  // edge_q holds the index k of the upcoming edge Ek, counted from the accept edge E0
  localparam int EW = $clog2(WIDTH + DET_LAT + 2);
  localparam logic [EW-1:0]   LAST_BIT  = EW'(WIDTH);
  localparam logic [EW-1:0]   FIRST_SMP = EW'(DET_LAT + 1);
  localparam logic [EW-1:0]   LAST_SMP  = EW'(WIDTH + DET_LAT);
  localparam logic [CNTW-1:0] HIT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [WIDTH-2:0]  sreg_q, sreg_d;
  logic              ser_q, ser_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              lp_q, lp_d;
  logic              id_q, id_d;
  logic [CNTW-1:0]   hit_q, hit_d;

  logic              pick1;
  logic [WIDTH-1:0]  win_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      edge_q  <= '0;
      sreg_q  <= '0;
      ser_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      lp_q    <= 1'b1;
      id_q    <= 1'b0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      sreg_q  <= sreg_d;
      ser_q   <= ser_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      lp_q    <= lp_d;
      id_q    <= id_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = SHIFT;
      SHIFT:   if (edge_q == LAST_BIT) state_d = DRAIN;
      DRAIN:   if (edge_q == LAST_SMP) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On a tie the requester that was not served last wins
  assign pick1    = req1 & (~req0 | ~lp_q);
  assign win_data = pick1 ? data1 : data0;

  always_comb begin
    edge_d = edge_q;
    sreg_d = sreg_q;
    ser_d  = ser_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    lp_d   = lp_q;
    id_d   = id_q;
    hit_d  = hit_q;
    if (state_q == IDLE) begin
      if (req0 || req1) begin
        ser_d  = win_data[WIDTH-1];
        sreg_d = win_data[WIDTH-2:0];
        gnt0_d = ~pick1;
        gnt1_d = pick1;
        lp_d   = pick1;
        id_d   = pick1;
        hit_d  = '0;
        edge_d = EW'(1);
      end
    end else begin
      edge_d = edge_q + EW'(1);
      if (state_q == SHIFT) begin
        if (edge_q == LAST_BIT) begin
          ser_d = 1'b0;
        end else begin
          ser_d  = sreg_q[WIDTH-2];
          sreg_d = sreg_q << 1;
        end
      end
      // Only the WIDTH samples aligned with this word's bits are counted
      if (edge_q >= FIRST_SMP && edge_q <= LAST_SMP && det_in && hit_q != HIT_MAX)
        hit_d = hit_q + CNTW'(1);
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign ser_out = ser_q;
  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done_id = id_q;
  assign hit_cnt = hit_q;

endmodule

// File: tb/tb_serial_feed_arbiter.sv
// Bench for serial_feed_arbiter: three parameterisations (default, CNTW=2,
// DET_LAT=2) each fed by a delay-line detector stub and checked every cycle.
module tb_serial_feed_arbiter;

  localparam int W = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       req0 [3];
  logic       req1 [3];
  logic [7:0] data0 [3];
  logic [7:0] data1 [3];
  logic       gnt0_o [3];
  logic       gnt1_o [3];
  logic       ser_o [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       id_o [3];
  logic [3:0] hc_a;
  logic [1:0] hc_b;
  logic [3:0] hc_c;

  logic       det_a = 1'b0;
  logic       det_b = 1'b0;
  logic [1:0] det_c = 2'b00;

  // Detector stubs: the serial stream delayed by DET_LAT cycles
  always @(posedge clock) begin
    det_a <= ser_o[0];
    det_b <= ser_o[1];
    det_c <= {det_c[0], ser_o[2]};
  end

  serial_feed_arbiter u_a (
    .clock(clock), .reset(reset), .req0(req0[0]), .req1(req1[0]),
    .data0(data0[0]), .data1(data1[0]), .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]),
    .ser_out(ser_o[0]), .det_in(det_a), .busy(busy_o[0]), .done(done_o[0]),
    .done_id(id_o[0]), .hit_cnt(hc_a));

  serial_feed_arbiter #(.CNTW(2)) u_b (
    .clock(clock), .reset(reset), .req0(req0[1]), .req1(req1[1]),
    .data0(data0[1]), .data1(data1[1]), .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]),
    .ser_out(ser_o[1]), .det_in(det_b), .busy(busy_o[1]), .done(done_o[1]),
    .done_id(id_o[1]), .hit_cnt(hc_b));

  serial_feed_arbiter #(.DET_LAT(2)) u_c (
    .clock(clock), .reset(reset), .req0(req0[2]), .req1(req1[2]),
    .data0(data0[2]), .data1(data1[2]), .gnt0(gnt0_o[2]), .gnt1(gnt1_o[2]),
    .ser_out(ser_o[2]), .det_in(det_c[1]), .busy(busy_o[2]), .done(done_o[2]),
    .done_id(id_o[2]), .hit_cnt(hc_c));

  int dl   [3] = '{1, 1, 2};
  int hmax [3] = '{15, 3, 15};

  // Transaction-level reference: t counts edges since the accept edge
  bit         m_busy [3];
  int         m_t    [3];
  logic [7:0] m_word [3];
  int         m_id   [3];
  int         m_lp   [3];
  int         m_hit  [3];
  int         m_acc  [3];

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;
  int cur_inst = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    num_checks++;
    if (observed != expected) begin
      num_errors++;
      $display("[TB] FAIL %s inst=%0d cycle=%0d observed=%0d expected=%0d",
               tag, cur_inst, cyc, observed, expected);
    end
  endtask

  function automatic int top_hits(input logic [7:0] w, input int n);
    int c = 0;
    for (int b = 0; b < n; b++) c += int'(w[7-b]);
    return c;
  endfunction

  task automatic model_edge(input int i);
    int win;
    int n;
    m_acc[i] = -1;
    if (reset) begin
      m_busy[i] = 1'b0;
      m_lp[i]   = 1;
      m_id[i]   = 0;
      m_hit[i]  = 0;
    end else if (m_busy[i]) begin
      m_t[i]++;
      if (m_t[i] > W + dl[i]) m_busy[i] = 1'b0;
    end else if (req0[i] || req1[i]) begin
      win       = (req0[i] && (!req1[i] || m_lp[i] == 1)) ? 0 : 1;
      m_busy[i] = 1'b1;
      m_t[i]    = 0;
      m_word[i] = (win == 0) ? data0[i] : data1[i];
      m_id[i]   = win;
      m_lp[i]   = win;
      m_acc[i]  = win;
    end
    if (m_busy[i]) begin
      n = m_t[i] - dl[i];
      if (n < 0) n = 0;
      if (n > W) n = W;
      m_hit[i] = top_hits(m_word[i], n);
      if (m_hit[i] > hmax[i]) m_hit[i] = hmax[i];
    end
  endtask

  function automatic int hit_obs(input int i);
    if (i == 0) return int'(hc_a);
    if (i == 1) return int'(hc_b);
    return int'(hc_c);
  endfunction

  task automatic step();
    int e_ser;
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      cur_inst = i;
      e_ser = (m_busy[i] && m_t[i] < W) ? int'(m_word[i][W-1-m_t[i]]) : 0;
      checkOutput("gnt0", int'(gnt0_o[i]), int'(m_busy[i] && m_t[i] == 0 && m_id[i] == 0));
      checkOutput("gnt1", int'(gnt1_o[i]), int'(m_busy[i] && m_t[i] == 0 && m_id[i] == 1));
      checkOutput("ser_out", int'(ser_o[i]), e_ser);
      checkOutput("busy", int'(busy_o[i]), int'(m_busy[i]));
      checkOutput("done", int'(done_o[i]), int'(m_busy[i] && m_t[i] == W + dl[i]));
      checkOutput("done_id", int'(id_o[i]), m_id[i]);
      checkOutput("hit_cnt", hit_obs(i), m_hit[i]);
      if (m_acc[i] == 0) req0[i] = 1'b0;
      if (m_acc[i] == 1) req1[i] = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic applyStimulus(input bit r0, input logic [7:0] d0, input bit r1, input logic [7:0] d1);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      if (r0) begin req0[i] = 1'b1; data0[i] = d0; end
      if (r1) begin req1[i] = 1'b1; data1[i] = d1; end
    end
  endtask

  task automatic set_reset(input bit v);
    @(negedge clock);
    reset = v;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; data0[i] = 8'h00; data1[i] = 8'h00;
      m_busy[i] = 1'b0; m_t[i] = 0; m_word[i] = 8'h00;
      m_id[i] = 0; m_lp[i] = 1; m_hit[i] = 0; m_acc[i] = -1;
    end
    run(2);
    set_reset(1'b0);

    // Single request, then a tie that requester 0 must win after reset
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    run(14);
    set_reset(1'b1);
    run(1);
    set_reset(1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b1, 8'hFF);
    run(26);

    // Saturation on the narrow counter, then a light word after it
    applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00);
    run(14);
    applyStimulus(1'b1, 8'h01, 1'b0, 8'h00);
    run(14);

    // Abort a word at E3, then serve requester 1
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
    run(3);
    set_reset(1'b1);
    run(1);
    set_reset(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
    run(14);

    // Random traffic with occasional resets
    repeat (3000) begin
      @(negedge clock);
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!req0[i] && $urandom_range(0, 2) == 0) begin
          req0[i] = 1'b1; data0[i] = 8'($urandom);
        end
        if (!req1[i] && $urandom_range(0, 2) == 0) begin
          req1[i] = 1'b1; data1[i] = 8'($urandom);
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
